// File: rtl/sum_display_driver.sv
// Binary-to-BCD (iterative double dabble) and two-digit
// multiplexed 7-segment driver for the nibble-adder sum.
module sum_display_driver #(
    parameter int SUM_W       = 5,
    parameter int REFRESH_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [1:0]       dig_en
);

    localparam int SCR_W = SUM_W + 8;
    localparam int BC_W  = 3;
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int ONE_L = SUM_W;
    localparam int TEN_L = SUM_W + 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SCR_W-1:0] r_scr;
    logic [SCR_W-1:0] w_scr_next;
    logic [SCR_W-1:0] w_adj;
    logic [BC_W-1:0]  r_bitcnt;
    logic [BC_W-1:0]  w_bitcnt_next;
    logic             w_latch;
    logic             r_busy;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dig_en;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg;

    // Add-3 correction on each BCD nibble ahead of the shift
    always_comb begin
        w_adj = r_scr;
        if (r_scr[ONE_L +: 4] >= 4'd5)
            w_adj[ONE_L +: 4] = r_scr[ONE_L +: 4] + 4'd3;
        if (r_scr[TEN_L +: 4] >= 4'd5)
            w_adj[TEN_L +: 4] = r_scr[TEN_L +: 4] + 4'd3;
    end

    // Conversion FSM next-state and datapath control
    always_comb begin
        w_next        = r_state;
        w_scr_next    = r_scr;
        w_bitcnt_next = r_bitcnt;
        w_latch       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (sum_valid) begin
                    w_scr_next    = {8'd0, sum_in};
                    w_bitcnt_next = '0;
                    w_next        = SHIFT;
                end
            end
            SHIFT: begin
                w_scr_next    = w_adj << 1;
                w_bitcnt_next = r_bitcnt + 3'd1;
                if (r_bitcnt == BC_W'(SUM_W - 1))
                    w_next = LATCH;
            end
            LATCH: begin
                w_latch = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state, scratch register and held display digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_scr    <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_tens   <= 4'd0;
            r_ones   <= 4'd0;
        end else begin
            r_state  <= w_next;
            r_scr    <= w_scr_next;
            r_bitcnt <= w_bitcnt_next;
            r_busy   <= (w_next != IDLE);
            if (w_latch) begin
                r_tens <= r_scr[TEN_L +: 4];
                r_ones <= r_scr[ONE_L +: 4];
            end
        end
    end

    // Free-running refresh counter; digit select flips on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dig_en <= 2'b01;
        end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_cnt    <= '0;
            r_dig_en <= ~r_dig_en;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Segment decode with tens leading-zero blanking
    always_comb begin
        w_digit = r_dig_en[1] ? r_tens : r_ones;
        unique case (w_digit)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h00;
        endcase
        if (r_dig_en[1] && (r_tens == 4'd0))
            w_seg = 7'h00;
    end

    assign busy   = r_busy;
    assign seg    = w_seg;
    assign dig_en = r_dig_en;

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver with a
// latency-level reference model and random stimulus.
module tb_sum_display_driver;

    localparam int SUM_W = 5;
    localparam int RD    = 4;

    logic             clk;
    logic             rst_n;
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             busy;
    logic [6:0]       seg;
    logic [1:0]       dig_en;

    int errors = 0;
    int checks = 0;

    sum_display_driver #(
        .SUM_W(SUM_W),
        .REFRESH_DIV(RD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sum_in(sum_in),
        .sum_valid(sum_valid),
        .busy(busy),
        .seg(seg),
        .dig_en(dig_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] codes [10];
    initial begin
        codes[0] = 7'h3F; codes[1] = 7'h06; codes[2] = 7'h5B;
        codes[3] = 7'h4F; codes[4] = 7'h66; codes[5] = 7'h6D;
        codes[6] = 7'h7D; codes[7] = 7'h07; codes[8] = 7'h7F;
        codes[9] = 7'h6F;
    end

    // Reference model: a conversion is a fixed delay of SUM_W+1
    // edges after acceptance; no acceptance while one is pending.
    int m_rem;
    int m_pend;
    int m_disp;
    int m_cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_pend <= 0;
            m_disp <= 0;
            m_cyc  <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_rem == 0) begin
                if (sum_valid) begin
                    m_pend <= int'(sum_in);
                    m_rem  <= SUM_W + 1;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_disp <= m_pend;
            end
        end
    end

    function automatic logic [1:0] exp_dig();
        return (((m_cyc / RD) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg();
        int t;
        int o;
        t = m_disp / 10;
        o = m_disp % 10;
        if (exp_dig() == 2'b10) return (t == 0) ? 7'h00 : codes[t];
        return codes[o];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", int'(busy), int'(m_rem != 0));
            chk("dig_en", int'(dig_en), int'(exp_dig()));
            chk("seg", int'(seg), int'(exp_seg()));
        end
    end

    task automatic send(input int v);
        @(posedge clk); #1;
        sum_in    = SUM_W'(v);
        sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_valid = 1'b0;
    endtask

    task automatic seg_on(input logic [1:0] want, input int exp, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dig_en == want) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, int'(dig_en), int'(want));
        else chk(name, int'(seg), exp);
    endtask

    logic [1:0] seq [10];

    initial begin
        rst_n     = 1'b0;
        sum_in    = '0;
        sum_valid = 1'b0;
        seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01; seq[3] = 2'b01;
        seq[4] = 2'b10; seq[5] = 2'b10; seq[6] = 2'b10; seq[7] = 2'b10;
        seq[8] = 2'b01; seq[9] = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_seg", int'(seg), 'h3F);
        rst_n  = 1'b1;
        cmp_en = 1;

        // Idle refresh sequence from reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_seq", int'(dig_en), int'(seq[i]));
            chk("idle_busy", int'(busy), 0);
            chk("idle_seg", int'(seg), (seq[i] == 2'b01) ? 'h3F : 'h00);
        end

        // 30: busy window and displayed digits
        send(30);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("busy_win", int'(busy), 1);
        end
        @(negedge clk);
        chk("busy_end", int'(busy), 0);
        seg_on(2'b01, 'h3F, "s30_ones");
        seg_on(2'b10, 'h4F, "s30_tens");

        // 7: tens blanked
        send(7);
        repeat (8) @(posedge clk);
        seg_on(2'b01, 'h07, "s7_ones");
        seg_on(2'b10, 'h00, "s7_tens");

        // 12 then 25 while busy: 25 dropped
        send(12);
        repeat (2) @(posedge clk);
        #1;
        sum_in = 5'd25;
        sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_valid = 1'b0;
        repeat (8) @(posedge clk);
        seg_on(2'b10, 'h06, "s12_tens");
        seg_on(2'b01, 'h5B, "s12_ones");

        // Reset mid-conversion aborts
        send(19);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_seg", int'(seg), 'h3F);
        chk("abort_dig", int'(dig_en), 'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(19);
        repeat (8) @(posedge clk);
        seg_on(2'b10, 'h06, "s19_tens");
        seg_on(2'b01, 'h6F, "s19_ones");

        // Boundaries: zero and max
        send(0);
        repeat (8) @(posedge clk);
        seg_on(2'b10, 'h00, "s0_tens");
        seg_on(2'b01, 'h3F, "s0_ones");
        send(31);
        repeat (8) @(posedge clk);
        seg_on(2'b10, 'h4F, "s31_tens");
        seg_on(2'b01, 'h06, "s31_ones");

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            sum_in    = SUM_W'($urandom_range(0, 31));
            sum_valid = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        sum_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        cmp_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
